bp_be_dcache_port_arb: RTL

BP_BE_DCACHE_PORT_ARB -- requirements
Module: bp_be_dcache_port_arb

---
 rtl/bp_be_dcache_port_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bp_be_dcache_port_arb.sv
// Arbitrates the single D$ port between the page-table walker and the pipeline,
// with PTW port locking, pipe anti-starvation, and a 2-stage response tracker.
module bp_be_dcache_port_arb #(
    parameter int pkt_width_p    = 84,
    parameter int ptag_width_p   = 28,
    parameter int starve_limit_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    ptw_v_i,
    input  logic [pkt_width_p-1:0]  ptw_pkt_i,
    input  logic [ptag_width_p-1:0] ptw_ptag_i,
    input  logic                    ptw_lock_i,
    output logic                    ptw_ready_o,

    input  logic                    pipe_v_i,
    input  logic [pkt_width_p-1:0]  pipe_pkt_i,
    input  logic [ptag_width_p-1:0] pipe_ptag_i,
    output logic                    pipe_ready_o,

    input  logic                    flush_i,

    output logic                    dcache_v_o,
    output logic [pkt_width_p-1:0]  dcache_pkt_o,
    output logic [ptag_width_p-1:0] dcache_ptag_o,
    input  logic                    dcache_ready_i,
    input  logic                    dcache_early_v_i,

    output logic                    ptw_resp_v_o,
    output logic                    pipe_resp_v_o,
    output logic                    pipe_miss_o,
    output logic                    ptw_owner_o
);

    // Handshake: a request is accepted in any cycle where dcache_v_o and
    // dcache_ready_i are both high; only the granted side sees ready_o high.

    localparam logic [7:0] StarveLimit = 8'(starve_limit_p);

    typedef enum logic {
        E_IDLE     = 1'b0,
        E_PTW_LOCK = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] starve_q, starve_d;
    logic [1:0] trk_v_q, trk_v_d;
    logic [1:0] trk_ptw_q, trk_ptw_d;

    logic ptw_gnt, pipe_gnt, pipe_ok, starved;
    logic accept, ptw_acc, pipe_acc;

    assign pipe_ok = pipe_v_i & ~flush_i;
    assign starved = (starve_q == StarveLimit);

    // Grants are gated by reset so every handshake output is low while in reset.
    always_comb begin
        ptw_gnt  = 1'b0;
        pipe_gnt = 1'b0;
        if (reset_n_i) begin
            if (state_q == E_PTW_LOCK) begin
                ptw_gnt = ptw_v_i;
            end else if (pipe_ok && (starved || !ptw_v_i)) begin
                pipe_gnt = 1'b1;
            end else begin
                ptw_gnt = ptw_v_i;
            end
        end
    end

    assign dcache_v_o    = ptw_gnt | pipe_gnt;
    assign dcache_pkt_o  = ptw_gnt ? ptw_pkt_i  : pipe_pkt_i;
    assign dcache_ptag_o = ptw_gnt ? ptw_ptag_i : pipe_ptag_i;
    assign ptw_ready_o   = ptw_gnt  & dcache_ready_i;
    assign pipe_ready_o  = pipe_gnt & dcache_ready_i;

    assign accept   = dcache_v_o & dcache_ready_i;
    assign ptw_acc  = accept & ptw_gnt;
    assign pipe_acc = accept & pipe_gnt;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            E_IDLE: begin
                if (ptw_acc && ptw_lock_i) state_d = E_PTW_LOCK;
                if (pipe_acc || flush_i) begin
                    starve_d = 8'd0;
                end else if (pipe_v_i && (starve_q < StarveLimit)) begin
                    starve_d = starve_q + 8'd1;
                end
            end
            E_PTW_LOCK: begin
                if (ptw_acc && !ptw_lock_i) state_d = E_IDLE;
            end
            default: state_d = E_IDLE;
        endcase
    end

    // A flush kills the pipe-owned entry leaving stage 0 as it shifts onward.
    always_comb begin
        trk_v_d      = 2'b00;
        trk_ptw_d    = 2'b00;
        trk_v_d[0]   = accept;
        trk_ptw_d[0] = ptw_gnt;
        trk_v_d[1]   = trk_v_q[0] & ~(flush_i & ~trk_ptw_q[0]);
        trk_ptw_d[1] = trk_ptw_q[0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= E_IDLE;
            starve_q  <= 8'd0;
            trk_v_q   <= 2'b00;
            trk_ptw_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            trk_v_q   <= trk_v_d;
            trk_ptw_q <= trk_ptw_d;
        end
    end

    assign ptw_resp_v_o  = trk_v_q[1] &  trk_ptw_q[1] &  dcache_early_v_i;
    assign pipe_resp_v_o = trk_v_q[1] & ~trk_ptw_q[1] &  dcache_early_v_i & ~flush_i;
    assign pipe_miss_o   = trk_v_q[1] & ~trk_ptw_q[1] & ~dcache_early_v_i & ~flush_i;

    // The two-state FSM is fully visible through the owner flag.
    assign ptw_owner_o = (state_q == E_PTW_LOCK);

endmodule
